// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding and PC constants.
package mips_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [5:0]  OPCODE_BEQ       = 6'b000100;
  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/ack plus the valid/ready link to decode.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [15:0]       branch_imm;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, redirect, branch_imm
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready, redirect, branch_imm
  );
endinterface

// File: rtl/fetch_unit_pc_next_calc.sv
// Sequential/branch next-PC adder: basePc + 4, plus sext(imm) << 2 when redirect is set.
module pc_next_calc
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] basePc,
  input  logic              redirect,
  input  logic [15:0]       branchImm,
  output logic [ADDR_W-1:0] nextPc
);

  logic [ADDR_W-1:0] seqPc;
  logic [ADDR_W-1:0] offset;

  always_comb begin
    seqPc  = basePc + ADDR_W'(PC_STEP);
    // Sign-extend to full width first so the shift keeps negative offsets negative.
    offset = {{(ADDR_W-16){branchImm[15]}}, branchImm} << 2;
    nextPc = redirect ? (seqPc + offset) : seqPc;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, single outstanding imem request, holds one word for decode.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instrReg;
  logic [ADDR_W-1:0] instrPcReg;
  logic              instrValidReg;
  logic [ADDR_W-1:0] pcNext;

  pc_next_calc #(.ADDR_W(ADDR_W)) uPcNext (
    .basePc   (instrPcReg),
    .redirect (bus.redirect),
    .branchImm(bus.branch_imm),
    .nextPc   (pcNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      instrReg      <= '0;
      instrPcReg    <= '0;
      instrValidReg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (bus.imem_ack) begin
            instrReg      <= bus.imem_rdata;
            instrPcReg    <= pc;
            instrValidReg <= 1'b1;
            state         <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instrValidReg && bus.instr_ready) begin
            instrValidReg <= 1'b0;
            pc            <= pcNext;
            state         <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req    = (state == S_FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr       = instrReg;
  assign bus.instr_pc    = instrPcReg;
  assign bus.instr_valid = instrValidReg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: latency, stalls, redirects, wrap and mid-run reset.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int unsigned checks;
  int unsigned errors;

  fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) busA ();
  fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) busB ();

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dutA (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busA.master)
  );

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dutB (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busB.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-wait fetch at expPc, then accept with the given redirect/imm; expects the next request at expNext.
  task automatic fetchAccept(input string tag, input logic [31:0] rdata, input logic redir,
                             input logic [15:0] imm, input logic [31:0] expPc,
                             input logic [31:0] expNext);
    check({tag, "_req"}, 32'(busA.imem_req), 32'd1);
    check({tag, "_addr"}, busA.imem_addr, expPc);
    busA.imem_ack   = 1'b1;
    busA.imem_rdata = rdata;
    tick();
    busA.imem_ack   = 1'b0;
    check({tag, "_valid"}, 32'(busA.instr_valid), 32'd1);
    check({tag, "_instr"}, busA.instr, rdata);
    check({tag, "_ipc"}, busA.instr_pc, expPc);
    busA.instr_ready = 1'b1;
    busA.redirect    = redir;
    busA.branch_imm  = imm;
    tick();
    busA.instr_ready = 1'b0;
    busA.redirect    = 1'b0;
    busA.branch_imm  = 16'h0;
    check({tag, "_validClr"}, 32'(busA.instr_valid), 32'd0);
    check({tag, "_nreq"}, 32'(busA.imem_req), 32'd1);
    check({tag, "_naddr"}, busA.imem_addr, expNext);
  endtask

  function automatic logic [31:0] beqWord(input logic [15:0] imm);
    return {6'b000100, 5'd1, 5'd2, imm};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    busA.imem_ack = 1'b0; busA.imem_rdata = '0; busA.instr_ready = 1'b0;
    busA.redirect = 1'b0; busA.branch_imm = '0;
    busB.imem_ack = 1'b0; busB.imem_rdata = '0; busB.instr_ready = 1'b0;
    busB.redirect = 1'b0; busB.branch_imm = '0;

    // Reset state
    tick();
    check("rst_req", 32'(busA.imem_req), 32'd0);
    check("rst_valid", 32'(busA.instr_valid), 32'd0);
    check("rst_instr", busA.instr, 32'd0);
    check("rst_ipc", busA.instr_pc, 32'd0);
    check("rst_addr", busA.imem_addr, 32'd0);
    check("rstB_addr", busB.imem_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;
    check("idle_req", 32'(busA.imem_req), 32'd0);
    tick();

    // Zero-wait memory: fetch 0x0, accept -> 0x4
    fetchAccept("zw", 32'h2008_0001, 1'b0, 16'h0, 32'h0, 32'h4);

    // Memory ack delayed 3 cycles at 0x4
    for (int i = 0; i < 3; i++) begin
      check("dly_req", 32'(busA.imem_req), 32'd1);
      check("dly_addr", busA.imem_addr, 32'h4);
      check("dly_valid", 32'(busA.instr_valid), 32'd0);
      tick();
    end
    busA.imem_ack   = 1'b1;
    busA.imem_rdata = 32'h8C08_0004;
    tick();
    busA.imem_ack   = 1'b0;
    busA.imem_rdata = 32'hDEAD_BEEF;
    check("dly_valid1", 32'(busA.instr_valid), 32'd1);
    check("dly_instr", busA.instr, 32'h8C08_0004);
    check("dly_ipc", busA.instr_pc, 32'h4);

    // Decode stalls 5 cycles; stray acks, redirect and rdata changes must not disturb anything
    for (int i = 0; i < 5; i++) begin
      busA.imem_ack   = i[0];
      busA.redirect   = 1'b1;
      busA.branch_imm = 16'h0100;
      busA.imem_rdata = 32'h1111_0000 + 32'(i);
      tick();
      check("stall_instr", busA.instr, 32'h8C08_0004);
      check("stall_ipc", busA.instr_pc, 32'h4);
      check("stall_req", 32'(busA.imem_req), 32'd0);
      check("stall_valid", 32'(busA.instr_valid), 32'd1);
    end
    busA.imem_ack    = 1'b0;
    busA.redirect    = 1'b0;
    busA.instr_ready = 1'b1;
    tick();
    busA.instr_ready = 1'b0;
    check("stall_nreq", 32'(busA.imem_req), 32'd1);
    check("stall_naddr", busA.imem_addr, 32'h8);

    // Redirects: 0x8 +4 +5*4 = 0x20; then the three beq cases at instr_pc 0x20
    fetchAccept("br_to20", beqWord(16'h0005), 1'b1, 16'h0005, 32'h8, 32'h20);
    fetchAccept("br_neg", beqWord(16'hFFFE), 1'b1, 16'hFFFE, 32'h20, 32'h1C);
    fetchAccept("seq_1c", 32'h0000_0020, 1'b0, 16'h0, 32'h1C, 32'h20);
    fetchAccept("br_pos", beqWord(16'h0003), 1'b1, 16'h0003, 32'h20, 32'h30);
    fetchAccept("br_back", beqWord(16'hFFFB), 1'b1, 16'hFFFB, 32'h30, 32'h20);
    fetchAccept("br_nt", beqWord(16'hFFFE), 1'b0, 16'hFFFE, 32'h20, 32'h24);

    // Wrap-around on the second instance: 0xFFFF_FFFC + 4 = 0
    check("wrap_req", 32'(busB.imem_req), 32'd1);
    check("wrap_addr", busB.imem_addr, 32'hFFFF_FFFC);
    busB.imem_ack   = 1'b1;
    busB.imem_rdata = 32'h0000_0000;
    tick();
    busB.imem_ack    = 1'b0;
    check("wrap_ipc", busB.instr_pc, 32'hFFFF_FFFC);
    busB.instr_ready = 1'b1;
    tick();
    busB.instr_ready = 1'b0;
    check("wrap_naddr", busB.imem_addr, 32'h0);
    check("wrap_nreq", 32'(busB.imem_req), 32'd1);

    // Reset during S_FETCH (0x24) with a pending ack
    busA.imem_ack   = 1'b1;
    busA.imem_rdata = 32'hCAFE_0001;
    #2 rst_n = 1'b0;
    #1;
    check("rstF_req", 32'(busA.imem_req), 32'd0);
    check("rstF_addr", busA.imem_addr, 32'd0);
    check("rstF_valid", 32'(busA.instr_valid), 32'd0);
    tick();
    check("rstF_instr", busA.instr, 32'd0);
    check("rstF_valid2", 32'(busA.instr_valid), 32'd0);
    busA.imem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rstF_restart_req", 32'(busA.imem_req), 32'd1);
    check("rstF_restart_addr", busA.imem_addr, 32'd0);

    // Reset during S_HOLD
    busA.imem_ack   = 1'b1;
    busA.imem_rdata = 32'h1234_5678;
    tick();
    busA.imem_ack = 1'b0;
    check("rstH_instr", busA.instr, 32'h1234_5678);
    #2 rst_n = 1'b0;
    #1;
    check("rstH_valid", 32'(busA.instr_valid), 32'd0);
    check("rstH_instr0", busA.instr, 32'd0);
    check("rstH_ipc", busA.instr_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    check("rstH_idle_req", 32'(busA.imem_req), 32'd0);
    tick();
    check("rstH_restart_req", 32'(busA.imem_req), 32'd1);
    check("rstH_restart_addr", busA.imem_addr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
